// File: rtl/gameport_pkg.sv
// Shared constants and the axis target mapping for the game port timer.
// Bit indices follow the joy_digital layout of each joystick byte.
package gameport_pkg;

  localparam int CNT_MIN_BITS = 8;
  localparam int CNT_MAX_BITS = 12;

  localparam int BIT_RIGHT = 0;
  localparam int BIT_LEFT  = 1;
  localparam int BIT_DOWN  = 2;
  localparam int BIT_UP    = 3;
  localparam int BIT_BTN1  = 4;
  localparam int BIT_BTN2  = 5;

  localparam logic [CNT_MAX_BITS-1:0] TGT_ONE = CNT_MAX_BITS'(1);

  // lo = left/up, hi = right/down; analog value is signed 8-bit
  function automatic logic [CNT_MAX_BITS-1:0] calc_target(
    input logic       dig,
    input logic       lo,
    input logic       hi,
    input logic [7:0] v,
    input int         cbits
  );
    logic [CNT_MAX_BITS-1:0] t;
    t = CNT_MAX_BITS'({~v[7], v[6:0]}) << (cbits - CNT_MIN_BITS);
    if (dig) begin
      unique case ({lo, hi})
        2'b10:   t = '0;
        2'b01:   t = (TGT_ONE << cbits) - TGT_ONE;
        default: t = TGT_ONE << (cbits - 1);
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/gameport_tick_gen.sv
// Prescaler: one tick every (cpu_speed+1)*16 clocks.
// The limit is compared live, so a speed change acts on the next compare.
module gameport_tick_gen (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic [4:0] cpu_speed,
  input  logic       clear,
  output logic       tick
);

  logic [8:0] pre;
  logic [8:0] lim;

  assign lim  = {cpu_speed, 4'hF};
  assign tick = !clear && (pre >= lim);

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (clear || (pre >= lim)) begin
      pre <= '0;
    end else begin
      pre <= pre + 9'd1;
    end
  end

endmodule

// File: rtl/gameport_timer.sv
// PC game port one-shot emulation: axis timing bits and button bits.
// A write arms all axes; each drops once the count reaches its target.
module gameport_timer
  import gameport_pkg::*;
#(
  parameter int NUM_JOY  = 2,
  parameter int CNT_BITS = 8
) (
  input  logic                   clk_cpu,
  input  logic                   reset,
  input  logic [4:0]             cpu_speed,
  input  logic                   gpio_wr,
  input  logic [NUM_JOY*8-1:0]   joy_digital,
  input  logic [NUM_JOY*16-1:0]  joy_analog,
  input  logic [NUM_JOY-1:0]     digital_mode,
  input  logic                   swap,
  output logic [4*NUM_JOY-1:0]   port_out,
  output logic                   busy
);

  localparam int NA = 2 * NUM_JOY;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [CNT_BITS-1:0]     count;
  logic [CNT_MAX_BITS-1:0] cnt_ext;
  logic [NA-1:0]           axis;
  logic [NA-1:0]           hit;
  logic [NA-1:0]           btn_d;
  logic [NA-1:0]           btn_q;
  logic                    busy_q;
  logic                    tick;

  gameport_tick_gen u_tick (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .cpu_speed (cpu_speed),
    .clear     (gpio_wr),
    .tick      (tick)
  );

  assign cnt_ext = CNT_MAX_BITS'(count);

  for (genvar j = 0; j < NUM_JOY; j++) begin : g_joy
    localparam int R = NUM_JOY - 1 - j;
    logic [7:0]  dj;
    logic [15:0] aj;
    logic        mj;
    logic        unused_hi;

    assign dj = swap ? joy_digital[8*R +: 8] : joy_digital[8*j +: 8];
    assign aj = swap ? joy_analog[16*R +: 16] : joy_analog[16*j +: 16];
    assign mj = swap ? digital_mode[R] : digital_mode[j];
    assign unused_hi = ^dj[7:6];

    assign hit[2*j] = cnt_ext == calc_target(
      mj, dj[BIT_LEFT], dj[BIT_RIGHT], aj[7:0], CNT_BITS);
    assign hit[2*j+1] = cnt_ext == calc_target(
      mj, dj[BIT_UP], dj[BIT_DOWN], aj[15:8], CNT_BITS);
    assign btn_d[2*j +: 2] = ~{dj[BIT_BTN2], dj[BIT_BTN1]};
  end

  // count parks at CNT_MAX when idle; reaching it ends the measurement
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      count  <= CNT_MAX;
      axis   <= '0;
      busy_q <= 1'b0;
      btn_q  <= '1;
    end else begin
      btn_q <= btn_d;
      if (gpio_wr) begin
        count  <= '0;
        axis   <= '1;
        busy_q <= 1'b1;
      end else if (count == CNT_MAX) begin
        axis   <= '0;
        busy_q <= 1'b0;
      end else begin
        axis <= axis & ~hit;
        if (tick) count <= count + CNT_BITS'(1);
      end
    end
  end

  assign port_out = {btn_q, axis};
  assign busy     = busy_q;

endmodule
